regfile_banked: RTL and testbench



---
 rtl/regfile_banked_pkg.sv | 15 +
 rtl/regfile_banked_mem.sv | 33 +++
 rtl/regfile_banked.sv | 122 ++++++++++++
 tb/tb_regfile_banked.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_banked_pkg.sv
// regfile_banked_pkg: shared state encoding and bank-width helper for the banked register file
package regfile_banked_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLR_ALL = 2'd1,
        CLR_ONE = 2'd2
    } state_e;

    // A single bank still needs a one-bit select so port widths never collapse to zero
    function automatic int bank_bits(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/regfile_banked_mem.sv
// regfile_banked_mem: NB x 2^AW x DW storage, one synchronous write port, three asynchronous read ports
module regfile_banked_mem #(
    parameter int DW = 32,
    parameter int AW = 4,
    parameter int NB = 2,
    parameter int BW = 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [BW-1:0] wbank,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [BW-1:0] rbank,
    input  logic [AW-1:0] raddr0,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] mem_q [NB][2**AW];

    // Storage has no reset; the clear sequencer defines its contents
    always_ff @(posedge clk) begin
        if (we) mem_q[wbank][waddr] <= wdata;
    end

    assign rdata0 = mem_q[rbank][raddr0];
    assign rdata1 = mem_q[rbank][raddr1];
    assign rdata2 = mem_q[rbank][raddr2];

endmodule

// File: rtl/regfile_banked.sv
// regfile_banked: banked register file with clear sequencer, write bypass and busy-gated reads
module regfile_banked
    import regfile_banked_pkg::*;
#(
    parameter int DW     = 32,
    parameter int AW     = 4,
    parameter int NB     = 2,
    parameter int BYPASS = 1,
    localparam int BW    = bank_bits(NB)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [BW-1:0] bsel,
    input  logic          wr,
    input  logic [AW-1:0] wno,
    input  logic [DW-1:0] din,
    input  logic [AW-1:0] rno0,
    input  logic [AW-1:0] rno1,
    input  logic [AW-1:0] rno2,
    output logic [DW-1:0] dout0,
    output logic [DW-1:0] dout1,
    output logic [DW-1:0] dout2,
    input  logic          clr,
    input  logic [BW-1:0] clr_bank,
    output logic          busy
);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [BW-1:0] cbank_q, cbank_d;

    logic          mem_we;
    logic [BW-1:0] mem_bank;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] rd0, rd1, rd2;
    logic          byp;

    assign busy = (state_q != IDLE);

    // Sequencer next state: sweep every bank after reset, or one latched bank on request
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        cbank_d = cbank_q;
        case (state_q)
            CLR_ALL: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) begin
                    bcnt_d = bcnt_q + 1'b1;
                    if (bcnt_q == BW'(NB - 1)) state_d = IDLE;
                end
            end
            CLR_ONE: begin
                cnt_d = cnt_q + 1'b1;
                if (&cnt_q) state_d = IDLE;
            end
            IDLE: begin
                if (clr) begin
                    cbank_d = clr_bank;
                    cnt_d   = '0;
                    state_d = CLR_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers; reset restarts the full sweep from bank 0, address 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_ALL;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            cbank_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            cbank_q <= cbank_d;
        end
    end

    // Write port owner: the sequencer while busy (CPU writes dropped), the CPU otherwise
    always_comb begin
        mem_we   = busy | wr;
        mem_bank = (state_q == CLR_ALL) ? bcnt_q : (state_q == CLR_ONE) ? cbank_q : bsel;
        mem_addr = busy ? cnt_q : wno;
        mem_din  = busy ? '0 : din;
    end

    regfile_banked_mem #(
        .DW(DW),
        .AW(AW),
        .NB(NB),
        .BW(BW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .wbank (mem_bank),
        .waddr (mem_addr),
        .wdata (mem_din),
        .rbank (bsel),
        .raddr0(rno0),
        .raddr1(rno1),
        .raddr2(rno2),
        .rdata0(rd0),
        .rdata1(rd1),
        .rdata2(rd2)
    );

    // Read outputs: zero while clearing, else bypassed write data or stored value
    always_comb begin
        byp   = (BYPASS != 0) && wr && !busy;
        dout0 = busy ? '0 : (byp && rno0 == wno) ? din : rd0;
        dout1 = busy ? '0 : (byp && rno1 == wno) ? din : rd1;
        dout2 = busy ? '0 : (byp && rno2 == wno) ? din : rd2;
    end

endmodule

// File: tb/tb_regfile_banked.sv
// tb_regfile_banked: scoreboard bench for the banked register file with and without bypass
module tb_regfile_banked;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NB = 2;
    localparam int BW = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [BW-1:0] bsel = '0;
    logic          wr = 1'b0;
    logic [AW-1:0] wno = '0;
    logic [DW-1:0] din = '0;
    logic [AW-1:0] rno0 = '0, rno1 = '0, rno2 = '0;
    logic          clr = 1'b0;
    logic [BW-1:0] clr_bank = '0;
    logic [DW-1:0] dout0, dout1, dout2;
    logic          busy;
    logic [DW-1:0] nb_dout0, nb_dout1, nb_dout2;
    logic          nb_busy;

    always #5 clk = ~clk;

    regfile_banked #(.DW(DW), .AW(AW), .NB(NB), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .bsel(bsel), .wr(wr), .wno(wno), .din(din),
        .rno0(rno0), .rno1(rno1), .rno2(rno2),
        .dout0(dout0), .dout1(dout1), .dout2(dout2),
        .clr(clr), .clr_bank(clr_bank), .busy(busy)
    );

    regfile_banked #(.DW(DW), .AW(AW), .NB(NB), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .bsel(bsel), .wr(wr), .wno(wno), .din(din),
        .rno0(rno0), .rno1(rno1), .rno2(rno2),
        .dout0(nb_dout0), .dout1(nb_dout1), .dout2(nb_dout2),
        .clr(clr), .clr_bank(clr_bank), .busy(nb_busy)
    );

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] v;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic [31:0] act;
    int          n_chk = 0;
    int          n_fail = 0;
    int          n_wait = 0;

    function automatic logic [31:0] pick(input int s);
        case (s)
            0:       return dout0;
            1:       return dout1;
            2:       return dout2;
            3:       return {31'b0, busy};
            4:       return nb_dout1;
            default: return {31'b0, nb_busy};
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sig, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            act = pick(cur.sig);
            n_chk++;
            if (act !== cur.v) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", cur.tag, act, cur.v);
            end
        end
    end

    initial begin
        tick();
        for (int i = 0; i < 3; i++) begin
            push_exp("rst_busy", 3, 1);
            push_exp("rst_dout0", 0, 0);
            push_exp("rst_dout2", 2, 0);
            tick();
        end
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rno0 = AW'(i);
            push_exp("init_busy", 3, 1);
            push_exp("init_dout0", 0, 0);
            push_exp("init_nb_busy", 5, 1);
            tick();
        end
        push_exp("init_done", 3, 0);
        @(negedge clk);
        #1;
        check_now("direct_init_busy", {31'b0, busy}, 0);
        check_now("direct_init_dout0", dout0, 0);
        check_now("direct_init_nb_busy", {31'b0, nb_busy}, 0);
        for (int b = 0; b < NB; b++) begin
            for (int r = 0; r < 16; r++) begin
                bsel = BW'(b);
                rno1 = AW'(r);
                push_exp("init_zero", 1, 0);
                tick();
            end
        end

        bsel = 0; wr = 1; wno = 5; din = 32'hDEADBEEF;
        rno0 = 0; rno1 = 0; rno2 = 0;
        tick();
        wr = 0; rno0 = 5; rno1 = 5; rno2 = 5;
        push_exp("wr_rd0", 0, 32'hDEADBEEF);
        push_exp("wr_rd1", 1, 32'hDEADBEEF);
        push_exp("wr_rd2", 2, 32'hDEADBEEF);
        tick();
        bsel = 1;
        push_exp("other_bank", 0, 0);
        tick();

        bsel = 0; wr = 1; wno = 3; din = 32'h12345678; rno1 = 3; rno0 = 5;
        push_exp("bypass", 1, 32'h12345678);
        push_exp("no_bypass", 4, 0);
        push_exp("bypass_other_port", 0, 32'hDEADBEEF);
        tick();
        wr = 0;
        push_exp("after_bypass", 1, 32'h12345678);
        push_exp("nb_after_write", 4, 32'h12345678);
        tick();

        bsel = 1; wr = 1;
        for (int i = 0; i < 16; i++) begin
            wno = AW'(i);
            din = 32'h100 + i;
            tick();
        end
        wr = 0; rno2 = 4; rno0 = 15;
        push_exp("fill_r4", 2, 32'h104);
        push_exp("fill_r15", 0, 32'h10F);
        tick();
        bsel = 0; wr = 1; wno = 7; din = 32'hA5;
        tick();
        wr = 0; clr = 1; clr_bank = 1; rno0 = 7;
        push_exp("pre_clr_busy", 3, 0);
        push_exp("pre_clr_r7", 0, 32'hA5);
        tick();
        clr = 0;
        for (int i = 0; i < 16; i++) begin
            wr = (i == 3);
            wno = 2;
            din = 32'h55;
            clr = (i == 6);
            clr_bank = 0;
            push_exp("clr_busy", 3, 1);
            push_exp("clr_gate", 0, 0);
            tick();
        end
        wr = 0; clr = 0;
        push_exp("clr_done", 3, 0);
        bsel = 1;
        for (int r = 0; r < 16; r++) begin
            rno1 = AW'(r);
            push_exp("bank1_zero", 1, 0);
            tick();
        end
        bsel = 0; rno0 = 7; rno1 = 2; rno2 = 5;
        push_exp("bank0_kept", 0, 32'hA5);
        push_exp("dropped_wr", 1, 0);
        push_exp("bank0_r5", 2, 32'hDEADBEEF);
        tick();

        wr = 1; wno = 9; din = 32'h77; clr = 1; clr_bank = 0;
        push_exp("wrclr_idle", 3, 0);
        tick();
        wr = 0; clr = 0;
        for (int i = 0; i < 16; i++) begin
            push_exp("wrclr_busy", 3, 1);
            tick();
        end
        rno0 = 9; rno1 = 7;
        push_exp("wrclr_done", 3, 0);
        push_exp("wrclr_r9", 0, 0);
        push_exp("wrclr_r7", 1, 0);
        tick();

        bsel = 1; wr = 1; wno = 3; din = 32'hCAFE;
        tick();
        wr = 0; rno2 = 3;
        push_exp("cafe", 2, 32'hCAFE);
        clr = 1; clr_bank = 0;
        tick();
        clr = 0;
        for (int i = 0; i < 5; i++) begin
            push_exp("mid_busy", 3, 1);
            tick();
        end
        rst_n = 0;
        for (int i = 0; i < 2; i++) begin
            push_exp("mid_rst_busy", 3, 1);
            push_exp("mid_rst_dout", 2, 0);
            tick();
        end
        rst_n = 1;
        for (int i = 0; i < 32; i++) begin
            push_exp("rerun_busy", 3, 1);
            tick();
        end
        push_exp("rerun_done", 3, 0);
        push_exp("rerun_b1r3", 2, 0);
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        n_wait = 0;
        while (busy && n_wait < 40) begin
            tick();
            n_wait++;
        end
        n_chk++;
        if (busy) begin
            n_fail++;
            $display("FAIL wait_busy_fall: busy still high after %0d cycles", n_wait);
        end
        check_now("wait_len", n_wait, 32);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
